// File: rtl/hbridge_pkg.sv
// Shared H-bridge definitions: sweep states, default widths/limits and the
// saturating period step used by the sweep sequencer.
package hbridge_pkg;

  localparam int HB_W      = 32;
  localparam int HB_DW     = 32;
  localparam int HB_P_MIN  = 50;
  localparam int HB_P_IDLE = 500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_DWELL,
    ST_STEP,
    ST_STOP
  } sweep_state_e;

  // Move cur toward stop by inc without overshooting stop. The remaining
  // distance is compared before adding, so no W-bit wrap can occur.
  function automatic logic [HB_W-1:0] sat_step(input logic [HB_W-1:0] cur,
                                               input logic [HB_W-1:0] stop,
                                               input logic [HB_W-1:0] inc,
                                               input logic            up);
    logic [HB_W-1:0] remain;
    logic [HB_W-1:0] result;
    remain = up ? (stop - cur) : (cur - stop);
    if (inc >= remain) begin
      result = stop;
    end else begin
      result = up ? (cur + inc) : (cur - inc);
    end
    return result;
  endfunction

endpackage

// File: rtl/sweep_scheduler_if.sv
// Control/status bundle between the sweep sequencer and its host/bridge.
interface sweep_scheduler_if
  import hbridge_pkg::*;
#(
  parameter int W  = HB_W,
  parameter int DW = HB_DW
);
  logic          i_start;
  logic          i_abort;
  logic          i_cycle_end;
  logic [W-1:0]  i_p_start;
  logic [W-1:0]  i_p_stop;
  logic [W-1:0]  i_p_step;
  logic [DW-1:0] i_dwell;
  logic [W-1:0]  o_period;
  logic          o_enable;
  logic          o_busy;
  logic          o_step;
  logic          o_done;
  logic          o_aborted;

  modport master (
    output i_start, i_abort, i_cycle_end, i_p_start, i_p_stop, i_p_step, i_dwell,
    input  o_period, o_enable, o_busy, o_step, o_done, o_aborted
  );

  modport slave (
    input  i_start, i_abort, i_cycle_end, i_p_start, i_p_stop, i_p_step, i_dwell,
    output o_period, o_enable, o_busy, o_step, o_done, o_aborted
  );
endinterface

// File: rtl/sweep_scheduler_dwell_timer.sv
// Clearable, non-wrapping dwell counter; expired once count reaches limit-1.
module sweep_scheduler_dwell_timer #(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [DW-1:0] i_limit,
  output logic          o_expired
);
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Limit is never zero (the sequencer maps 0 to 1 when latching).
  assign o_expired = (cnt_q >= (i_limit - DW'(1)));
endmodule

// File: rtl/sweep_scheduler.sv
// Frequency-sweep sequencer for the H-bridge half-period register. Period and
// enable changes are taken only on carrier wrap (i_cycle_end); reset is the
// one exception and drops the enable at once.
module sweep_scheduler
  import hbridge_pkg::*;
#(
  parameter int W      = HB_W,
  parameter int DW     = HB_DW,
  parameter int P_MIN  = HB_P_MIN,
  parameter int P_IDLE = HB_P_IDLE
) (
  input  logic             i_clk,
  input  logic             i_reset,
  sweep_scheduler_if.slave bus
);
  localparam logic [W-1:0] PMIN_V  = W'(P_MIN);
  localparam logic [W-1:0] PIDLE_V = W'(P_IDLE);

  sweep_state_e  state_q, state_d;
  logic [W-1:0]  period_q, period_d;
  logic [W-1:0]  stop_q, stop_d;
  logic [W-1:0]  inc_q, inc_d;
  logic [DW-1:0] lim_q, lim_d;
  logic          up_q, up_d;
  logic          enable_q, enable_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          tmr_clr, tmr_en, tmr_expired;
  logic [W-1:0]  s_clamped, e_clamped, next_period;

  sweep_scheduler_dwell_timer #(.DW(DW)) u_dwell (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (tmr_clr),
    .i_en     (tmr_en),
    .i_limit  (lim_q),
    .o_expired(tmr_expired)
  );

  // Next-state and register-update logic of the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    stop_d      = stop_q;
    inc_d       = inc_q;
    lim_d       = lim_q;
    up_d        = up_q;
    enable_d    = enable_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    s_clamped   = (bus.i_p_start < PMIN_V) ? PMIN_V : bus.i_p_start;
    e_clamped   = (bus.i_p_stop  < PMIN_V) ? PMIN_V : bus.i_p_stop;
    next_period = sat_step(period_q, stop_q, inc_q, up_q);
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          period_d = s_clamped;
          stop_d   = e_clamped;
          inc_d    = (bus.i_p_step == '0) ? W'(1) : bus.i_p_step;
          lim_d    = (bus.i_dwell == '0) ? DW'(1) : bus.i_dwell;
          up_d     = (e_clamped > s_clamped);
          state_d  = ST_ARM;
        end
      end
      ST_ARM: begin
        if (bus.i_abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.i_cycle_end) begin
          enable_d = 1'b1;
          tmr_clr  = 1'b1;
          state_d  = ST_DWELL;
        end
      end
      ST_DWELL, ST_STEP: begin
        if (bus.i_abort) begin
          if (bus.i_cycle_end) begin
            enable_d  = 1'b0;
            aborted_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end else if (state_q == ST_STEP) begin
          if (bus.i_cycle_end) begin
            if (period_q == stop_q) begin
              enable_d = 1'b0;
              done_d   = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              period_d = next_period;
              step_d   = 1'b1;
              tmr_clr  = 1'b1;
              state_d  = ST_DWELL;
            end
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) state_d = ST_STEP;
        end
      end
      ST_STOP: begin
        if (bus.i_cycle_end) begin
          enable_d  = 1'b0;
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      period_q  <= PIDLE_V;
      stop_q    <= PIDLE_V;
      inc_q     <= W'(1);
      lim_q     <= DW'(1);
      up_q      <= 1'b0;
      enable_q  <= 1'b0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      stop_q    <= stop_d;
      inc_q     <= inc_d;
      lim_q     <= lim_d;
      up_q      <= up_d;
      enable_q  <= enable_d;
      step_q    <= step_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.o_period  = period_q;
  assign bus.o_enable  = enable_q & ~i_reset;
  assign bus.o_busy    = (state_q != ST_IDLE);
  assign bus.o_step    = step_q;
  assign bus.o_done    = done_q;
  assign bus.o_aborted = aborted_q;
endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler: sweeps, clamping, aborts, reset.
module tb_sweep_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sweep_scheduler_if #(.W(32), .DW(32)) bus ();

  sweep_scheduler #(.W(32), .DW(32), .P_MIN(50), .P_IDLE(500)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor: cumulative counters, sampled on the falling edge.
  int          n_step = 0, n_done = 0, n_abort = 0, n_rise = 0, n_glitch = 0;
  logic        done_en = 1'b0;
  logic        prev_busy = 1'b0, prev_en = 1'b0;
  logic [31:0] prev_period = 32'd0;
  logic [31:0] hist[$];

  always @(negedge clk) begin
    if (bus.o_step === 1'b1) n_step++;
    if (bus.o_done === 1'b1) begin
      n_done++;
      done_en = bus.o_enable;
    end
    if (bus.o_aborted === 1'b1) n_abort++;
    if (bus.o_enable === 1'b1 && prev_en !== 1'b1) n_rise++;
    if (bus.o_busy === 1'b1 && prev_busy !== 1'b1) hist.push_back(bus.o_period);
    if (bus.o_step === 1'b1) hist.push_back(bus.o_period);
    if (bus.o_busy === 1'b1 && prev_busy === 1'b1 && bus.o_step !== 1'b1 &&
        bus.o_period !== prev_period) n_glitch++;
    prev_busy   = bus.o_busy;
    prev_en     = bus.o_enable;
    prev_period = bus.o_period;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("check %s ok value=%0d", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One 8-clock carrier period, i_cycle_end on its last clock.
  task automatic carrier();
    repeat (7) tick();
    bus.i_cycle_end = 1'b1;
    tick();
    bus.i_cycle_end = 1'b0;
  endtask

  task automatic start_sweep(input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] st, input logic [31:0] dw);
    bus.i_p_start = s;
    bus.i_p_stop  = e;
    bus.i_p_step  = st;
    bus.i_dwell   = dw;
    bus.i_start   = 1'b1;
    tick();
    bus.i_start   = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int max_carriers, output int used);
    used = 0;
    while (bus.o_busy && used < max_carriers) begin
      carrier();
      used++;
    end
    check_eq({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic check_hist(input string tag, input int idx, input logic [31:0] exp);
    if (idx < hist.size()) check_eq(tag, hist[idx], exp);
    else                   check_eq(tag, 32'hFFFF_FFFF, exp);
  endtask

  // Full 500 -> 520 up sweep, used before and after the mid-sweep reset.
  task automatic up_sweep(input string tag);
    int bh, bs, bd, br, used;
    bh = hist.size(); bs = n_step; bd = n_done; br = n_rise;
    start_sweep(32'd500, 32'd520, 32'd10, 32'd4);
    check_eq({tag, "_arm_en"}, 32'(bus.o_enable), 32'd0);
    check_eq({tag, "_arm_busy"}, 32'(bus.o_busy), 32'd1);
    carrier();
    check_eq({tag, "_en_rise"}, 32'(bus.o_enable), 32'd1);
    run_until_idle(tag, 10, used);
    check_eq({tag, "_hist_len"}, 32'(hist.size() - bh), 32'd3);
    check_hist({tag, "_p0"}, bh,     32'd500);
    check_hist({tag, "_p1"}, bh + 1, 32'd510);
    check_hist({tag, "_p2"}, bh + 2, 32'd520);
    check_eq({tag, "_steps"}, 32'(n_step - bs), 32'd2);
    check_eq({tag, "_done"}, 32'(n_done - bd), 32'd1);
    check_eq({tag, "_rises"}, 32'(n_rise - br), 32'd1);
    check_eq({tag, "_en_at_done"}, 32'(done_en), 32'd0);
    check_eq({tag, "_hold"}, bus.o_period, 32'd520);
  endtask

  initial begin
    int bh, bs, bd, ba, br, used;
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_cycle_end = 1'b0;
    bus.i_p_start = '0; bus.i_p_stop = '0; bus.i_p_step = '0; bus.i_dwell = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_period", bus.o_period, 32'd500);
    check_eq("rst_enable", 32'(bus.o_enable), 32'd0);
    check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
    check_eq("rst_pulses", 32'({bus.o_step, bus.o_done, bus.o_aborted}), 32'd0);

    up_sweep("up");

    // Down sweep with saturation at the stop value.
    bh = hist.size(); bs = n_step; bd = n_done;
    start_sweep(32'd600, 32'd575, 32'd10, 32'd4);
    run_until_idle("down", 12, used);
    check_eq("down_hist_len", 32'(hist.size() - bh), 32'd4);
    check_hist("down_p0", bh,     32'd600);
    check_hist("down_p1", bh + 1, 32'd590);
    check_hist("down_p2", bh + 2, 32'd580);
    check_hist("down_p3", bh + 3, 32'd575);
    check_eq("down_steps", 32'(n_step - bs), 32'd3);
    check_eq("down_done", 32'(n_done - bd), 32'd1);
    check_eq("down_hold", bus.o_period, 32'd575);

    // Clamp to P_MIN, zero step and zero dwell.
    bh = hist.size(); bs = n_step; bd = n_done;
    start_sweep(32'd10, 32'd10, 32'd0, 32'd0);
    check_eq("clamp_period", bus.o_period, 32'd50);
    run_until_idle("clamp", 6, used);
    check_eq("clamp_carriers", 32'(used), 32'd2);
    check_eq("clamp_steps", 32'(n_step - bs), 32'd0);
    check_eq("clamp_done", 32'(n_done - bd), 32'd1);
    check_eq("clamp_hist_len", 32'(hist.size() - bh), 32'd1);
    check_eq("clamp_hold", bus.o_period, 32'd50);

    // Abort in DWELL, three clocks before the boundary.
    bd = n_done; ba = n_abort;
    start_sweep(32'd500, 32'd600, 32'd10, 32'd20);
    carrier();
    repeat (4) tick();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check_eq("abd_en_held", 32'(bus.o_enable), 32'd1);
    check_eq("abd_busy", 32'(bus.o_busy), 32'd1);
    tick();
    tick();
    bus.i_cycle_end = 1'b1;
    tick();
    bus.i_cycle_end = 1'b0;
    check_eq("abd_en_off", 32'(bus.o_enable), 32'd0);
    check_eq("abd_aborted", 32'(n_abort - ba), 32'd1);
    check_eq("abd_no_done", 32'(n_done - bd), 32'd0);
    check_eq("abd_period", bus.o_period, 32'd500);
    check_eq("abd_idle", 32'(bus.o_busy), 32'd0);

    // Abort in ARM: immediate IDLE, bridge never enabled.
    ba = n_abort; br = n_rise;
    start_sweep(32'd500, 32'd520, 32'd10, 32'd4);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check_eq("aba_idle", 32'(bus.o_busy), 32'd0);
    check_eq("aba_aborted", 32'(n_abort - ba), 32'd1);
    carrier();
    check_eq("aba_no_rise", 32'(n_rise - br), 32'd0);
    check_eq("aba_en", 32'(bus.o_enable), 32'd0);

    // Start while busy is ignored.
    bh = hist.size(); bs = n_step; bd = n_done;
    start_sweep(32'd500, 32'd520, 32'd10, 32'd20);
    carrier();
    start_sweep(32'd700, 32'd800, 32'd50, 32'd1);
    run_until_idle("busy", 20, used);
    check_eq("busy_hist_len", 32'(hist.size() - bh), 32'd3);
    check_hist("busy_p1", bh + 1, 32'd510);
    check_hist("busy_p2", bh + 2, 32'd520);
    check_eq("busy_steps", 32'(n_step - bs), 32'd2);
    check_eq("busy_done", 32'(n_done - bd), 32'd1);

    // Reset while waiting in STEP.
    start_sweep(32'd600, 32'd700, 32'd10, 32'd2);
    carrier();
    repeat (4) tick();
    check_eq("rst_mid_en_before", 32'(bus.o_enable), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_en_now", 32'(bus.o_enable), 32'd0);
    tick();
    rst = 1'b0;
    check_eq("rst_mid_en", 32'(bus.o_enable), 32'd0);
    check_eq("rst_mid_period", bus.o_period, 32'd500);
    check_eq("rst_mid_busy", 32'(bus.o_busy), 32'd0);
    tick();
    up_sweep("again");

    check_eq("no_stray_period_change", 32'(n_glitch), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
- Sequences the H-bridge half-period register (`period`, in clk_100M cycles) through a programmed frequency sweep, for automated resonant-tank frequency-response runs.
- Replaces manual button stepping: it loads a start period, dwells, steps by a fixed increment toward a stop period, then shuts the bridge down.
- Every `period` change and every enable edge happens only on a carrier-cycle boundary (`i_cycle_end`, the counter wrap pulse), so no runt pulses reach the dead-time stage.

Parameters:
- W, 32, width of period, start, stop and step values.
- DW, 32, width of the dwell counter.
- P_MIN, 50, minimum legal half-period; start and stop are clamped up to it (must exceed dead time).
- P_IDLE, 500, period output after reset (100 kHz carrier at 100 MHz).

Ports:
- i_clk  in  1  clk_100M domain clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  begin sweep; sampled only in IDLE.
- i_abort  in  1  stop sweep at the next cycle boundary.
- i_cycle_end  in  1  one-cycle pulse at the bridge counter wrap.
- i_p_start  in  W  first half-period.
- i_p_stop  in  W  final half-period.
- i_p_step  in  W  increment magnitude; 0 is treated as 1.
- i_dwell  in  DW  clocks to hold each period; 0 is treated as 1.
- o_period  out  W  half-period to the bridge counter.
- o_enable  out  1  bridge enable, ANDed with the SW0 enable.
- o_busy  out  1  high in every state except IDLE.
- o_step  out  1  one-cycle pulse on each period update.
- o_done  out  1  one-cycle pulse on normal completion.
- o_aborted  out  1  one-cycle pulse on abort completion.

Behaviour:
- Reset (synchronous, active-high): state IDLE, o_period=P_IDLE, o_enable=0, all pulse outputs 0, dwell counter 0. Reset mid-sweep forces this state on the next edge, and o_enable drops immediately (safety overrides the boundary rule).
- IDLE:
  - i_start=1 and i_abort=0: latch S=max(i_p_start,P_MIN), E=max(i_p_stop,P_MIN), step, dwell. Set dir=up if E>S. Load o_period<=S, go ARM.
  - Inputs are not re-sampled during a sweep.
- ARM:
  - On i_cycle_end: o_enable<=1, clear dwell counter, go DWELL.
  - On i_abort: go IDLE directly with an o_aborted pulse; the bridge was never enabled.
- DWELL: the dwell counter increments every clock. On reaching dwell-1, go STEP. The counter does not wrap.
- STEP: wait for i_cycle_end, then:
  - If o_period==E: o_enable<=0, pulse o_done, go IDLE.
  - Otherwise set o_period to next = period±step, saturated at E. This is never past E in either direction and uses no W-bit wrap: compute with W+1 bits, or compare the remaining distance before adding.
  - In the update case, also pulse o_step and go DWELL with the counter cleared.
- STOP (entered on i_abort from DWELL or STEP):
  - On i_cycle_end: o_enable<=0, pulse o_aborted, go IDLE.
  - If i_abort and i_cycle_end coincide in DWELL or STEP, the shutdown happens in that same cycle.
  - No period change occurs in STOP.
- Priorities: reset > abort > cycle_end event > dwell expiry. i_start is ignored when o_busy=1.
- Latencies:
  - o_enable rises on the clock edge that samples the first i_cycle_end after start.
  - Every o_period update is registered on the edge that samples i_cycle_end, so the new value applies from the next carrier cycle.
- After done or abort, o_period holds its last value until the next start.
- If S==E: one dwell at S, then done. There are zero o_step pulses.
- Total o_step pulses = ceil(|E−S|/step).

Decomposition:
- Shared package hbridge_pkg holds the state enum (IDLE, ARM, DWELL, STEP, STOP), W, DW, P_MIN and P_IDLE defaults, and a saturating step function, reused later by the frequency_control upgrade.
- One natural sub-module: dwell_timer, a loadable DW-bit counter with a clear input and an expiry flag.

Test Plan:
- Up sweep: S=500, E=520, step=10, dwell=4, i_cycle_end every 8 clocks. Required: o_period sequence 500→510→520, 2 o_step pulses, then o_done. o_enable goes low on the same edge as o_done; o_period holds 520.
- Down sweep with saturation: S=600, E=575, step=10. Required: o_period 600→590→580→575, 3 o_step pulses. It never goes below 575.
- Clamping and zero handling: S=10, E=10, step=0, dwell=0 with P_MIN=50. Required: o_period=50, one boundary of dwell, 0 o_step pulses, o_done.
- Abort in DWELL: i_abort 3 clocks before i_cycle_end. Required: o_enable stays 1 until that boundary, then 0 with an o_aborted pulse. No o_done; o_period unchanged.
- Abort in ARM and start-while-busy: abort before the first boundary gives an immediate IDLE with o_enable never asserted. A second i_start during DWELL changes nothing.
- Mid-sweep reset: reset during STEP. Required: next edge gives o_enable=0 and o_period=500 (P_IDLE). A subsequent i_start runs a full sweep normally.
